// File: rtl/fb_write_arbiter.sv
// Pixel-write port arbiter for the double-buffered LED panel frame buffer.
// Two game engines share one write port through round-robin bursts. A swap of the
// front/back buffer is sequenced here and lands only on a panel frame boundary.
module fb_write_arbiter #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  // Requester 0
  input  logic              req0,
  input  logic              last0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  output logic              ack0,
  // Requester 1
  input  logic              req1,
  input  logic              last1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              ack1,
  // Buffer swap handshake
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              frame_done,
  // Frame buffer write port
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_bank
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1,
    StSwapWait
  } state_e;

  state_e            state_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              rr_ptr_q;
  logic [CntW-1:0]   burst_cnt_q;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;
  logic              fb_bank_q;
  logic              swap_ack_q;
  logic [CntW-1:0]   cnt_inc;

  // Burst count after the accept happening this cycle.
  always_comb begin
    cnt_inc = burst_cnt_q + CntW'(1);
  end

  // Arbitration FSM; every output is a register except the combinational acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      fb_bank_q   <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      fb_we_q    <= 1'b0;
      swap_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          burst_cnt_q <= '0;
          // swap_req is still high while swap_ack is out; don't re-enter the swap.
          if (swap_req && !swap_ack_q) begin
            state_q <= StSwapWait;
          end else if (req0 && (!req1 || !rr_ptr_q)) begin
            state_q <= StGrant0;
            gnt0_q  <= 1'b1;
          end else if (req1) begin
            state_q <= StGrant1;
            gnt1_q  <= 1'b1;
          end
        end
        StGrant0: begin
          if (req0) begin
            fb_we_q     <= 1'b1;
            fb_addr_q   <= addr0;
            fb_data_q   <= data0;
            burst_cnt_q <= cnt_inc;
            if (last0 || (cnt_inc == BurstMax)) begin
              gnt0_q   <= 1'b0;
              rr_ptr_q <= 1'b1;
              state_q  <= StIdle;
            end
          end else begin
            gnt0_q   <= 1'b0;
            rr_ptr_q <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StGrant1: begin
          if (req1) begin
            fb_we_q     <= 1'b1;
            fb_addr_q   <= addr1;
            fb_data_q   <= data1;
            burst_cnt_q <= cnt_inc;
            if (last1 || (cnt_inc == BurstMax)) begin
              gnt1_q   <= 1'b0;
              rr_ptr_q <= 1'b0;
              state_q  <= StIdle;
            end
          end else begin
            gnt1_q   <= 1'b0;
            rr_ptr_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StSwapWait: begin
          if (frame_done) begin
            fb_bank_q  <= ~fb_bank_q;
            swap_ack_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign ack0     = gnt0_q & req0;
  assign ack1     = gnt1_q & req1;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign fb_bank  = fb_bank_q;
  assign swap_ack = swap_ack_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios with literal expectations plus a
// cycle-level behavioural model compared against the DUT on every falling edge.
module tb_fb_write_arbiter;

  localparam int MaxBurst = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, last0, req1, last1;
  logic [8:0] addr0, addr1;
  logic [2:0] data0, data1;
  logic       gnt0, ack0, gnt1, ack1;
  logic       swap_req, swap_ack, frame_done;
  logic       fb_we, fb_bank;
  logic [8:0] fb_addr;
  logic [2:0] fb_data;

  int n_total = 0;
  int n_pass  = 0;

  fb_write_arbiter #(
    .ADDR_W   (9),
    .DATA_W   (3),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .last0     (last0),
    .addr0     (addr0),
    .data0     (data0),
    .gnt0      (gnt0),
    .ack0      (ack0),
    .req1      (req1),
    .last1     (last1),
    .addr1     (addr1),
    .data1     (data1),
    .gnt1      (gnt1),
    .ack1      (ack1),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .frame_done(frame_done),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_bank   (fb_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Owner of the port (-1 = nobody), whose turn it is on a tie, writes in the
  // current burst, whether a swap is pending, and the expected write-port registers.
  int         m_owner = -1;
  int         m_turn  = 0;
  int         m_writes = 0;
  bit         m_swap = 0;
  bit         m_valid = 0;
  bit         m_bank = 0, m_we = 0, m_sack = 0;
  logic [8:0] m_addr = '0;
  logic [2:0] m_data = '0;
  bit         rq[2];
  bit         ls[2];
  logic [8:0] ad[2];
  logic [2:0] dt[2];

  always @(negedge clk) begin
    bit nw, ns;
    int n;
    if (m_valid) begin
      chk("gnt0", gnt0, m_owner == 0);
      chk("gnt1", gnt1, m_owner == 1);
      chk("ack0", ack0, (m_owner == 0) && req0);
      chk("ack1", ack1, (m_owner == 1) && req1);
      chk("fb_we", fb_we, m_we);
      chk("fb_addr", fb_addr, m_addr);
      chk("fb_data", fb_data, m_data);
      chk("fb_bank", fb_bank, m_bank);
      chk("swap_ack", swap_ack, m_sack);
    end
    // Predict the state after the coming rising edge from the inputs held now.
    rq[0] = req0;  rq[1] = req1;
    ls[0] = last0; ls[1] = last1;
    ad[0] = addr0; ad[1] = addr1;
    dt[0] = data0; dt[1] = data1;
    nw = 0;
    ns = 0;
    if (reset) begin
      m_owner = -1; m_turn = 0; m_writes = 0; m_swap = 0;
      m_bank = 0; m_addr = '0; m_data = '0;
      m_valid = 1;
    end else if (m_swap) begin
      if (frame_done) begin
        m_bank = !m_bank;
        ns = 1;
        m_swap = 0;
      end
    end else if (m_owner < 0) begin
      m_writes = 0;
      if (swap_req && !m_sack) m_swap = 1;
      else if (rq[0] && rq[1]) m_owner = m_turn;
      else if (rq[0]) m_owner = 0;
      else if (rq[1]) m_owner = 1;
    end else begin
      n = m_owner;
      if (rq[n]) begin
        nw = 1;
        m_addr = ad[n];
        m_data = dt[n];
        m_writes++;
        if (ls[n] || m_writes == MaxBurst) begin
          m_owner = -1;
          m_turn = 1 - n;
        end
      end else begin
        m_owner = -1;
        m_turn = 1 - n;
      end
    end
    m_we = nw;
    m_sack = ns;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end want end");
    $fatal(1, "timeout");
  end

  initial begin
    int hist[0:36];
    int g0_cnt;
    int w;

    reset = 1; req0 = 0; last0 = 0; req1 = 0; last1 = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    swap_req = 0; frame_done = 0;
    step(); step();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_bank", fb_bank, 0);
    reset = 0;

    // 1: three-write burst from requester 0
    req0 = 1; addr0 = 9'd10; data0 = 3'd1;
    step();
    chk("t1_gnt0", gnt0, 1);
    chk("t1_ack0", ack0, 1);
    chk("t1_we0", fb_we, 0);
    step();
    chk("t1_we1", fb_we, 1);
    chk("t1_addr1", fb_addr, 10);
    chk("t1_data1", fb_data, 1);
    addr0 = 9'd11; data0 = 3'd2;
    step();
    chk("t1_addr2", fb_addr, 11);
    addr0 = 9'd12; data0 = 3'd3; last0 = 1;
    step();
    chk("t1_addr3", fb_addr, 12);
    chk("t1_data3", fb_data, 3);
    chk("t1_rel", gnt0, 0);
    req0 = 0; last0 = 0;
    step();
    chk("t1_we_off", fb_we, 0);

    // 2: both requesters held, bursts of MAX_BURST with an idle gap
    reset = 1; step(); reset = 0;
    req0 = 1; req1 = 1;
    hist[0] = 0;
    g0_cnt = 0;
    for (int i = 1; i <= 36; i++) begin
      addr0 = 9'(i); data0 = 3'(i);
      addr1 = 9'(300 + i); data1 = 3'(i + 3);
      step();
      hist[i] = {30'd0, gnt1, gnt0};
      if (i <= 17 && gnt0) g0_cnt++;
    end
    chk("t2_first", hist[1], 1);
    chk("t2_b0_end", hist[16], 1);
    chk("t2_gap0", hist[17], 0);
    chk("t2_b1_start", hist[18], 2);
    chk("t2_b1_end", hist[33], 2);
    chk("t2_gap1", hist[34], 0);
    chk("t2_back0", hist[35], 1);
    chk("t2_len0", g0_cnt, 16);
    req0 = 0; req1 = 0;
    step(); step();

    // 3: swap requested mid-burst of requester 1 (rr now favours 1)
    req1 = 1; addr1 = 9'd200; data1 = 3'd6;
    step();
    chk("t3_gnt1", gnt1, 1);
    step();
    swap_req = 1; req0 = 1;
    step();
    last1 = 1;
    step();
    chk("t3_rel1", gnt1, 0);
    req1 = 0; last1 = 0;
    step(); step(); step();
    chk("t3_nogrant", gnt0, 0);
    chk("t3_bank0", fb_bank, 0);
    frame_done = 1;
    step();
    frame_done = 0; swap_req = 0;
    chk("t3_bank1", fb_bank, 1);
    chk("t3_sack", swap_ack, 1);
    step();
    chk("t3_sack_off", swap_ack, 0);
    chk("t3_gnt0", gnt0, 1);
    req0 = 0;
    step(); step();

    // 4: frame_done coincident with entry to swap wait is ignored
    swap_req = 1; frame_done = 1;
    step();
    frame_done = 0;
    step();
    chk("t4_noswap", fb_bank, 1);
    chk("t4_nosack", swap_ack, 0);
    frame_done = 1;
    step();
    frame_done = 0; swap_req = 0;
    chk("t4_swap", fb_bank, 0);
    frame_done = 1;
    step();
    frame_done = 0;
    step();
    chk("t4_idle_fd", fb_bank, 0);
    chk("t4_idle_sack", swap_ack, 0);

    // 5: requester 1 drops after two accepts
    req1 = 1; addr1 = 9'd7; data1 = 3'd5;
    w = 0;
    step(); w += int'(fb_we);
    chk("t5_gnt1", gnt1, 1);
    step(); w += int'(fb_we);
    step(); w += int'(fb_we);
    req1 = 0;
    step(); w += int'(fb_we);
    chk("t5_rel", gnt1, 0);
    chk("t5_addr", fb_addr, 7);
    req0 = 1; req1 = 1;
    step(); w += int'(fb_we);
    chk("t5_writes", w, 2);
    chk("t5_rr0", gnt0, 1);
    req0 = 0; req1 = 0;
    step(); step();

    // 6: reset in the middle of a burst
    swap_req = 1;
    step();
    frame_done = 1;
    step();
    frame_done = 0; swap_req = 0;
    chk("t6_bank1", fb_bank, 1);
    req0 = 1; addr0 = 9'd33; data0 = 3'd4;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("t6_writing", fb_we, 1);
    reset = 1;
    step();
    chk("t6_gnt0", gnt0, 0);
    chk("t6_gnt1", gnt1, 0);
    chk("t6_we", fb_we, 0);
    chk("t6_bank", fb_bank, 0);
    reset = 0; req1 = 1;
    step();
    chk("t6_rr_reset", gnt0, 1);
    req0 = 0;
    step();
    step();
    chk("t6_gnt1_alone", gnt1, 1);
    req1 = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
